conv_col_writer: RTL

Write-back engine for the convolution layer: captures each multi-channel output column (FP16, channels × column) on its valid strobe, packs it into 256-bit words and writes them sequentially into the PS-shared BRAM. It sits between the parallel edge-detection channels and BRAM port B, and is the write-side counterpart of the column reader that drives the BRAM read address. After the full feature map has been stored it reports completion to the controller.

---
 rtl/conv_col_writer_if.sv | 33 +++
 rtl/conv_col_writer.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/conv_col_writer_if.sv
// Signal bundle for conv_col_writer: column input stream, BRAM port-B write side and status.
// master = the writer, slave = whatever feeds columns and observes the BRAM writes.
interface conv_col_writer_if #(
    parameter int DATA_WIDTH      = 16,
    parameter int OUTPUT_CHANNELS = 4,
    parameter int OUTPUT_COL_SIZE = 24,
    parameter int BRAM_WIDTH      = 256,
    parameter int ADDR_WIDTH      = 12
);
    localparam int CNT_WIDTH = $clog2(OUTPUT_COL_SIZE + 1);

    logic                                                       start;
    logic [OUTPUT_CHANNELS-1:0][OUTPUT_COL_SIZE-1:0][DATA_WIDTH-1:0] col_in;
    logic                                                       col_valid;
    logic [ADDR_WIDTH-1:0]                                      bram_addr;
    logic [BRAM_WIDTH-1:0]                                      bram_din;
    logic                                                       bram_en;
    logic                                                       bram_we;
    logic                                                       busy;
    logic                                                       done;
    logic                                                       overflow;
    logic [CNT_WIDTH-1:0]                                       col_count;

    modport master (
        input  start, col_in, col_valid,
        output bram_addr, bram_din, bram_en, bram_we, busy, done, overflow, col_count
    );

    modport slave (
        output start, col_in, col_valid,
        input  bram_addr, bram_din, bram_en, bram_we, busy, done, overflow, col_count
    );
endinterface

// File: rtl/conv_col_writer.sv
// Convolution output write-back: packs each captured FP16 column into BRAM words and writes them
// sequentially from BASE_ADDR. Define CONV_WR_RELU_EN to zero sign-set elements at capture.
module conv_col_writer #(
    parameter int                    DATA_WIDTH      = 16,
    parameter int                    OUTPUT_CHANNELS = 4,
    parameter int                    OUTPUT_COL_SIZE = 24,
    parameter int                    BRAM_WIDTH      = 256,
    parameter int                    ADDR_WIDTH      = 12,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR       = 12'h200
) (
    input logic               clk,
    input logic               rst,
    conv_col_writer_if.master bus
);
    localparam int LANES  = BRAM_WIDTH / DATA_WIDTH;
    localparam int WPC    = (OUTPUT_COL_SIZE + LANES - 1) / LANES;
    localparam int BEATS  = OUTPUT_CHANNELS * WPC;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int CNT_W  = $clog2(OUTPUT_COL_SIZE + 1);

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
    localparam logic [CNT_W-1:0]  MAP_COLS  = CNT_W'(OUTPUT_COL_SIZE);

    typedef logic [OUTPUT_CHANNELS-1:0][OUTPUT_COL_SIZE-1:0][DATA_WIDTH-1:0] col_t;
    typedef enum logic [1:0] {IDLE, RUN, WRITE, FINISH} state_t;

    state_t                state;
    col_t                  act_buf;
    col_t                  hold_buf;
    col_t                  cap;
    logic                  hold_full;
    logic [BEAT_W-1:0]     beat;
    logic [CNT_W-1:0]      col_cnt;
    logic [CNT_W-1:0]      cnt_next;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [BRAM_WIDTH-1:0] wr_data;
    logic                  wr_en;
    logic                  busy_flag;
    logic                  done_flag;
    logic                  ovf_flag;

    function automatic col_t relu_filter(input col_t x);
        col_t y;
        y = x;
`ifdef CONV_WR_RELU_EN
        for (int unsigned c = 0; c < OUTPUT_CHANNELS; c++)
            for (int unsigned i = 0; i < OUTPUT_COL_SIZE; i++)
                if (x[c][i][DATA_WIDTH-1]) y[c][i] = '0;
`endif
        return y;
    endfunction

    // Beat b carries channel b/WPC, word b%WPC; lanes past the column end stay zero.
    function automatic logic [BRAM_WIDTH-1:0] word_of(input col_t b, input logic [BEAT_W-1:0] bt);
        logic [BRAM_WIDTH-1:0] w;
        int unsigned           bi, c, wi, idx;
        w  = '0;
        bi = 32'(bt);
        c  = bi / WPC;
        wi = bi % WPC;
        for (int unsigned k = 0; k < LANES; k++) begin
            idx = wi * LANES + k;
            if (idx < OUTPUT_COL_SIZE) w[k*DATA_WIDTH +: DATA_WIDTH] = b[c][idx];
        end
        return w;
    endfunction

    // (cc*CH + c)*WPC + w collapses to cc*BEATS + beat; truncation gives the silent wrap.
    function automatic logic [ADDR_WIDTH-1:0] addr_of(input logic [CNT_W-1:0] cc,
                                                       input logic [BEAT_W-1:0] bt);
        int unsigned a;
        a = 32'(BASE_ADDR) + 32'(cc) * BEATS + 32'(bt);
        return a[ADDR_WIDTH-1:0];
    endfunction

    always_comb cap = relu_filter(bus.col_in);
    always_comb cnt_next = col_cnt + CNT_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            act_buf   <= '0;
            hold_buf  <= '0;
            hold_full <= 1'b0;
            beat      <= '0;
            col_cnt   <= '0;
            wr_addr   <= '0;
            wr_data   <= '0;
            wr_en     <= 1'b0;
            busy_flag <= 1'b0;
            done_flag <= 1'b0;
            ovf_flag  <= 1'b0;
        end else begin
            done_flag <= 1'b0;
            case (state)
                IDLE: begin
                    wr_en <= 1'b0;
                    if (bus.start) begin
                        state     <= RUN;
                        busy_flag <= 1'b1;
                        col_cnt   <= '0;
                        ovf_flag  <= 1'b0;
                        hold_full <= 1'b0;
                    end
                end
                RUN: begin
                    if (bus.col_valid) begin
                        act_buf <= cap;
                        beat    <= '0;
                        state   <= WRITE;
                        wr_en   <= 1'b1;
                        wr_addr <= addr_of(col_cnt, '0);
                        wr_data <= word_of(cap, '0);
                    end
                end
                WRITE: begin
                    if (beat == LAST_BEAT) begin
                        col_cnt <= cnt_next;
                        beat    <= '0;
                        if (cnt_next == MAP_COLS) begin
                            state     <= FINISH;
                            wr_en     <= 1'b0;
                            done_flag <= 1'b1;
                            busy_flag <= 1'b0;
                            hold_full <= 1'b0;
                        end else if (hold_full) begin
                            // Hold moves to active first, so a same-cycle column refills hold.
                            act_buf   <= hold_buf;
                            wr_addr   <= addr_of(cnt_next, '0);
                            wr_data   <= word_of(hold_buf, '0);
                            hold_full <= bus.col_valid;
                            if (bus.col_valid) hold_buf <= cap;
                        end else if (bus.col_valid) begin
                            act_buf <= cap;
                            wr_addr <= addr_of(cnt_next, '0);
                            wr_data <= word_of(cap, '0);
                        end else begin
                            state <= RUN;
                            wr_en <= 1'b0;
                        end
                    end else begin
                        beat    <= beat + BEAT_W'(1);
                        wr_addr <= addr_of(col_cnt, beat + BEAT_W'(1));
                        wr_data <= word_of(act_buf, beat + BEAT_W'(1));
                        if (bus.col_valid) begin
                            if (!hold_full) begin
                                hold_buf  <= cap;
                                hold_full <= 1'b1;
                            end else begin
                                ovf_flag <= 1'b1;
                            end
                        end
                    end
                end
                FINISH: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.bram_addr = wr_addr;
    assign bus.bram_din  = wr_data;
    assign bus.bram_en   = wr_en;
    assign bus.bram_we   = wr_en;
    assign bus.busy      = busy_flag;
    assign bus.done      = done_flag;
    assign bus.overflow  = ovf_flag;
    assign bus.col_count = col_cnt;
endmodule
